// File: rtl/mpmc10_wb_pkg.sv
// rtl/mpmc10_wb_pkg.sv - wishbone 256-bit write request type shared by mpmc10 ports
package mpmc10_wb_pkg;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [31:0]  sel;
        logic [31:0]  adr;
        logic [255:0] dat;
    } wb_write_request256_t;

endpackage

// File: rtl/mpmc10_wr_arb256_wb.sv
// rtl/mpmc10_wr_arb256_wb.sv - round-robin arbiter for the 256-bit wishbone write path
//
// Shares one registered write-request path into the mpmc10 core among NPORT
// requesters. One port is granted at a time; its request is forwarded from a
// register, the grant is held across a cyc-locked burst of up to MAX_BURST
// beats, and a beat that sees no ack_i within TIMEOUT cycles is aborted with
// an err_o pulse to the owning port.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   req_i  per-port write requests (a port requests when cyc & stb)
//   ack_o  per-port one-cycle ack pulse per completed beat
//   err_o  per-port one-cycle pulse when a beat is aborted on timeout
//   gnt_o  one-hot current grant, zero when idle or releasing
//   req_o  registered request presented downstream
//   ack_i  downstream ack for the beat currently on req_o
module mpmc10_wr_arb256_wb
    import mpmc10_wb_pkg::*;
#(
    parameter int NPORT     = 8,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  wb_write_request256_t req_i [NPORT],
    output logic [NPORT-1:0]     ack_o,
    output logic [NPORT-1:0]     err_o,
    output logic [NPORT-1:0]     gnt_o,
    output wb_write_request256_t req_o,
    input  logic                 ack_i
);

    localparam int          PW       = $clog2(NPORT);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [8:0]  BEAT_MAX = 9'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ACKD,
        S_RELEASE
    } state_t;

    state_t               state, state_n;
    wb_write_request256_t req_q, req_n;
    logic [NPORT-1:0]     gnt_q, gnt_n;
    logic [NPORT-1:0]     ack_q, ack_n;
    logic [NPORT-1:0]     err_q, err_n;
    logic [PW-1:0]        gidx, gidx_n;
    logic [PW-1:0]        rr, rr_n;
    logic [8:0]           beat, beat_n;
    logic [15:0]          tmo, tmo_n;

    logic [NPORT-1:0]     port_req;
    logic                 pick_vld;
    logic [PW-1:0]        pick;
    logic [PW:0]          cand;
    wb_write_request256_t g_req;

    logic tmo_hit;
    logic burst_end;

    assign g_req     = req_i[gidx];
    assign tmo_hit   = (tmo >= TMO_LAST);
    assign burst_end = (beat >= BEAT_MAX) || !g_req.cyc;

    always_comb begin
        port_req = '0;
        for (int n = 0; n < NPORT; n++) begin
            port_req[n] = req_i[n].cyc & req_i[n].stb;
        end
    end

    // Scan downward so the candidate closest to rr (smallest offset) wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = rr;
        cand     = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            cand = {1'b0, rr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NPORT)) begin
                cand = cand - (PW+1)'(NPORT);
            end
            if (port_req[cand[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (pick_vld) state_n = S_ISSUE;
            end
            S_ISSUE: begin
                if (ack_i)        state_n = S_ACKD;
                else if (tmo_hit) state_n = S_RELEASE;
            end
            S_ACKD: begin
                if (burst_end)        state_n = S_RELEASE;
                else if (g_req.stb)   state_n = S_ISSUE;
                else if (tmo_hit)     state_n = S_RELEASE;
            end
            S_RELEASE: state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and counters; ack/err default low
    // so they only ever last one cycle.
    always_comb begin
        req_n  = req_q;
        gnt_n  = gnt_q;
        gidx_n = gidx;
        rr_n   = rr;
        beat_n = beat;
        tmo_n  = tmo;
        ack_n  = '0;
        err_n  = '0;
        case (state)
            S_IDLE: begin
                req_n.cyc = 1'b0;
                req_n.stb = 1'b0;
                if (pick_vld) begin
                    req_n  = req_i[pick];
                    gnt_n  = NPORT'(1) << pick;
                    gidx_n = pick;
                    beat_n = '0;
                    tmo_n  = '0;
                end
            end
            S_ISSUE: begin
                if (ack_i) begin
                    ack_n     = gnt_q;
                    req_n.stb = 1'b0;
                    beat_n    = beat + 9'd1;
                    tmo_n     = '0;
                end else if (tmo_hit) begin
                    req_n.cyc = 1'b0;
                    req_n.stb = 1'b0;
                    err_n     = gnt_q;
                    gnt_n     = '0;
                end else begin
                    tmo_n = tmo + 16'd1;
                end
            end
            S_ACKD: begin
                if (burst_end) begin
                    req_n.cyc = 1'b0;
                    req_n.stb = 1'b0;
                    gnt_n     = '0;
                end else if (g_req.stb) begin
                    req_n = g_req;
                    tmo_n = '0;
                end else if (tmo_hit) begin
                    // Locked gap ran out: release quietly, no beat was pending.
                    req_n.cyc = 1'b0;
                    req_n.stb = 1'b0;
                    gnt_n     = '0;
                end else begin
                    req_n.cyc = 1'b1;
                    req_n.stb = 1'b0;
                    tmo_n     = tmo + 16'd1;
                end
            end
            S_RELEASE: begin
                req_n.cyc = 1'b0;
                req_n.stb = 1'b0;
                gnt_n     = '0;
                rr_n      = (gidx == PW'(NPORT - 1)) ? '0 : gidx + PW'(1);
            end
            default: begin
                req_n.cyc = 1'b0;
                req_n.stb = 1'b0;
                gnt_n     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            gnt_q <= '0;
            ack_q <= '0;
            err_q <= '0;
            gidx  <= '0;
            rr    <= '0;
            beat  <= '0;
            tmo   <= '0;
        end else begin
            req_q <= req_n;
            gnt_q <= gnt_n;
            ack_q <= ack_n;
            err_q <= err_n;
            gidx  <= gidx_n;
            rr    <= rr_n;
            beat  <= beat_n;
            tmo   <= tmo_n;
        end
    end

    assign req_o = req_q;
    assign gnt_o = gnt_q;
    assign ack_o = ack_q;
    assign err_o = err_q;

endmodule

// File: tb/tb_mpmc10_wr_arb256_wb.sv
// tb/tb_mpmc10_wr_arb256_wb.sv - self-checking bench for mpmc10_wr_arb256_wb
module tb_mpmc10_wr_arb256_wb;
    import mpmc10_wb_pkg::*;

    localparam int NPORT = 8;
    localparam int MAXB  = 4;
    localparam int TMO   = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    wb_write_request256_t req_i [NPORT];
    logic [NPORT-1:0]     ack_o, err_o, gnt_o;
    wb_write_request256_t req_o;
    logic                 ack_i = 1'b0;

    mpmc10_wr_arb256_wb #(.NPORT(NPORT), .MAX_BURST(MAXB), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req_i),
        .ack_o (ack_o),
        .err_o (err_o),
        .gnt_o (gnt_o),
        .req_o (req_o),
        .ack_i (ack_i)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int want [NPORT];
    int per_grant [NPORT];
    int served [NPORT];
    int sess [NPORT];
    int ack_cnt [NPORT];
    int err_cnt [NPORT];
    int base_ack [NPORT];
    int base_err [NPORT];

    logic             stray = 1'b0;
    logic [NPORT-1:0] deaf = '0;
    int               ack_delay = 0;

    int got [$];
    int got_base = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int idx_of(input logic [NPORT-1:0] g);
        for (int i = 0; i < NPORT; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic new_payload(input int n);
        req_i[n].we  = 1'b1;
        req_i[n].sel = $urandom();
        req_i[n].adr = $urandom();
        req_i[n].dat = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Requesters: each port wants a number of beats, split into cyc sessions
    // of per_grant beats; it reacts to ack/err during the cycle they are seen.
    initial begin
        for (int n = 0; n < NPORT; n++) begin
            req_i[n] = '0;
            served[n] = 0; sess[n] = 0; ack_cnt[n] = 0; err_cnt[n] = 0;
        end
        forever begin
            @(negedge clk);
            for (int n = 0; n < NPORT; n++) begin
                if (ack_o[n]) begin
                    ack_cnt[n]++; served[n]++; sess[n]++;
                    if (served[n] >= want[n] || sess[n] >= per_grant[n]) begin
                        req_i[n].cyc = 1'b0; req_i[n].stb = 1'b0;
                    end else begin
                        new_payload(n);
                    end
                end else if (err_o[n]) begin
                    err_cnt[n]++; served[n] = want[n];
                    req_i[n].cyc = 1'b0; req_i[n].stb = 1'b0;
                end else if (req_i[n].cyc && served[n] >= want[n]) begin
                    req_i[n].cyc = 1'b0; req_i[n].stb = 1'b0;
                end else if (!req_i[n].cyc && served[n] < want[n]) begin
                    new_payload(n);
                    req_i[n].cyc = 1'b1; req_i[n].stb = 1'b1; sess[n] = 0;
                end
            end
        end
    end

    // Downstream: acks a strobed beat once it has been visible for more than
    // ack_delay cycles, unless the granted port is marked deaf; stray forces 1.
    initial begin
        int age;
        age = 0;
        forever begin
            @(negedge clk);
            if (req_o.stb) age++; else age = 0;
            ack_i = stray | (req_o.stb && age > ack_delay && ((gnt_o & deaf) == '0));
        end
    end

    // Rule model: a beat is the stretch of cycles req_o.stb is high; an ack_i
    // sampled during it is answered next cycle on ack_o, and TMO unanswered
    // strobe cycles are answered next cycle on err_o. Nothing else pulses.
    initial begin
        logic [NPORT-1:0] exp_ack, exp_err, prev_gnt;
        int cnt, gi;
        exp_ack = '0; exp_err = '0; prev_gnt = '0; cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk("rst_gnt", gnt_o, 0);
                chk("rst_ack", ack_o, 0);
                chk("rst_err", err_o, 0);
                chk("rst_cyc", req_o.cyc, 0);
                exp_ack = '0; exp_err = '0; cnt = 0; prev_gnt = '0;
            end else begin
                chk("ack_o", ack_o, exp_ack);
                chk("err_o", err_o, exp_err);
                chk("gnt_onehot", $onehot0(gnt_o), 1);
                chk("ack_err_excl", $countones(ack_o | err_o) <= 1, 1);
                if (req_o.stb) begin
                    gi = idx_of(gnt_o);
                    chk("stb_cyc", req_o.cyc, 1);
                    chk("stb_gnt", gi >= 0, 1);
                    if (gi >= 0)
                        chk("payload", (req_o.dat == req_i[gi].dat) && (req_o.adr == req_i[gi].adr)
                                       && (req_o.sel == req_i[gi].sel), 1);
                end
                exp_ack = (req_o.stb && ack_i) ? gnt_o : '0;
                if (req_o.stb && !ack_i) cnt++; else cnt = 0;
                exp_err = (req_o.stb && !ack_i && cnt >= TMO) ? gnt_o : '0;
                if (gnt_o != '0 && prev_gnt == '0) got.push_back(idx_of(gnt_o));
                prev_gnt = gnt_o;
            end
        end
    end

    task automatic start(input int p, input int beats, input int pg);
        want[p] = served[p] + beats;
        per_grant[p] = pg;
    endtask

    task automatic begin_test();
        got_base = got.size();
        for (int n = 0; n < NPORT; n++) begin
            base_ack[n] = ack_cnt[n];
            base_err[n] = err_cnt[n];
        end
    endtask

    function automatic bit all_done();
        for (int n = 0; n < NPORT; n++) if (served[n] < want[n]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_done(input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            @(posedge clk); #2;
            if (all_done() && gnt_o == '0 && !req_o.cyc) break;
        end
        chk("wait_done", c < budget, 1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    // seq holds grant indices, first grant in the lowest nibble.
    task automatic chk_order(input string name, input int n, input logic [31:0] seq);
        chk({name, "_len"}, got.size() - got_base, n);
        for (int i = 0; i < n; i++)
            if (got_base + i < got.size()) chk(name, got[got_base + i], seq[i*4 +: 4]);
    endtask

    task automatic chk_counts(input string name, input int p, input int acks, input int errs);
        chk({name, "_ack"}, ack_cnt[p] - base_ack[p], acks);
        chk({name, "_err"}, err_cnt[p] - base_err[p], errs);
    endtask

    initial begin
        int t_stb, t_ack, t_gz, t_err, t_cyc0, c;
        for (int n = 0; n < NPORT; n++) begin want[n] = 0; per_grant[n] = 1; end
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("init_gnt", gnt_o, 0);
        chk("init_req", req_o, 0);
        @(negedge clk); #3 rst_n = 1'b1;
        repeat (2) @(posedge clk); #2;

        // Single beat on port 2, ack 4 cycles into the strobe.
        begin_test();
        ack_delay = 3;
        start(2, 1, 1);
        t_stb = -1; t_ack = -1; t_gz = -1;
        for (c = 0; c < 40; c++) begin
            @(negedge clk); #2;
            if (t_stb < 0 && req_o.stb) t_stb = c;
            if (t_ack < 0 && ack_o[2]) t_ack = c;
            if (t_ack >= 0 && t_gz < 0 && gnt_o == '0) t_gz = c;
        end
        chk("t2_ack_lat", t_ack - t_stb, 4);
        chk("t2_gnt_clr", t_gz - t_stb, 5);
        run_until_done(100);
        chk_counts("t2_p2", 2, 1, 0);
        chk_order("t2_order", 1, 32'h2);
        ack_delay = 0;

        // rr now points at port 3.
        begin_test();
        start(1, 1, 1); start(3, 1, 1);
        run_until_done(100);
        chk_order("rr_after_2", 2, 32'h13);

        // Reset in the middle of an unanswered beat.
        begin_test();
        deaf = 8'h40;
        start(6, 1, 1);
        for (c = 0; c < 20 && !gnt_o[6]; c++) begin @(posedge clk); #2; end
        chk("t1_granted", gnt_o[6], 1);
        repeat (3) @(posedge clk);
        @(negedge clk); #3 rst_n = 1'b0;
        #1;
        chk("t1_cyc", req_o.cyc, 0);
        chk("t1_gnt", gnt_o, 0);
        chk("t1_ack", ack_o, 0);
        want[6] = served[6];
        repeat (2) @(posedge clk);
        @(negedge clk); #3 rst_n = 1'b1;
        deaf = '0;
        run_until_done(100);
        chk_counts("t1_p6", 6, 0, 0);

        // Round robin, one beat per grant, immediate ack.
        begin_test();
        start(0, 2, 1); start(3, 2, 1); start(5, 2, 1);
        run_until_done(300);
        chk_order("t3_order", 6, 32'h530530);
        chk_counts("t3_p0", 0, 2, 0);
        chk_counts("t3_p5", 5, 2, 0);

        // Burst cap: port 1 wants 6 locked beats, port 4 waiting.
        begin_test();
        start(1, 6, 99); start(4, 1, 1);
        run_until_done(300);
        chk_order("t4_order", 3, 32'h141);
        chk_counts("t4_p1", 1, 6, 0);
        chk_counts("t4_p4", 4, 1, 0);

        // Timeout on port 7, then port 0 served normally.
        begin_test();
        deaf = 8'h80;
        start(7, 1, 1); start(0, 1, 1);
        t_stb = -1; t_err = -1; t_cyc0 = -1;
        for (c = 0; c < 40; c++) begin
            @(negedge clk); #2;
            if (t_stb < 0 && req_o.stb) t_stb = c;
            if (t_err < 0 && err_o[7]) t_err = c;
            if (t_stb >= 0 && t_cyc0 < 0 && !req_o.cyc) t_cyc0 = c;
        end
        chk("t5_err_lat", t_err - t_stb, 16);
        chk("t5_cyc_drop", t_cyc0 - t_stb, 16);
        run_until_done(200);
        deaf = '0;
        chk_order("t5_order", 2, 32'h07);
        chk_counts("t5_p7", 7, 0, 1);
        chk_counts("t5_p0", 0, 1, 0);

        // Stray ack held high through IDLE and every ACKD cycle.
        begin_test();
        stray = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("t6_idle_gnt", gnt_o, 0);
        chk("t6_idle_cyc", req_o.cyc, 0);
        chk("t6_idle_ack", ack_o, 0);
        start(3, 3, 99);
        run_until_done(200);
        stray = 1'b0;
        chk_order("t6_order", 1, 32'h3);
        chk_counts("t6_p3", 3, 3, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
